mouse_receiver: RTL

//  PS/2 device-to-host receiver: deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop)

---
 rtl/mouse_receiver_if.sv | 21 ++
 rtl/mouse_receiver.sv | 127 ++++++++++++
 2 files changed

// File: rtl/mouse_receiver_if.sv
// PS/2 receive-side bundle: pad-level inputs plus received-byte outputs.
// BYTE_READY is a valid-only strobe with no ready: the consumer must take BYTE_READ/BYTE_ERROR_CODE in its pulse cycle.
interface mouse_receiver_if;
  logic       CLK_MOUSE_IN;
  logic       DATA_MOUSE_IN;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;
  logic [1:0] fsm_state;

  modport master (
    output CLK_MOUSE_IN, DATA_MOUSE_IN, READ_ENABLE,
    input  BYTE_READ, BYTE_ERROR_CODE, BYTE_READY, fsm_state
  );

  modport slave (
    input  CLK_MOUSE_IN, DATA_MOUSE_IN, READ_ENABLE,
    output BYTE_READ, BYTE_ERROR_CODE, BYTE_READY, fsm_state
  );
endinterface

// File: rtl/mouse_receiver.sv
// PS/2 device-to-host receiver: synchronises and glitch-filters the mouse clock,
// deserialises 11-bit frames and reports each byte with parity/framing flags.
module mouse_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic       CLK,
  input logic       RESET,
  mouse_receiver_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEIVE = 2'd1,
    CHECK   = 2'd2
  } state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk, filt_prev;
  logic [7:0]    filt_cnt;
  logic          fall;

  state_t        state, state_n;
  logic [3:0]    bit_cnt, bit_cnt_n;
  logic [9:0]    shift, shift_n;
  logic [TW-1:0] tmo_cnt, tmo_cnt_n;
  logic [7:0]    byte_q, byte_n;
  logic [1:0]    err_q, err_n;
  logic          ready_q, ready_n;

  // Line idles high, so synchronisers and filter come out of reset at 1.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      clk_s1    <= 1'b1;
      clk_s2    <= 1'b1;
      dat_s1    <= 1'b1;
      dat_s2    <= 1'b1;
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      clk_s1    <= bus.CLK_MOUSE_IN;
      clk_s2    <= clk_s1;
      dat_s1    <= bus.DATA_MOUSE_IN;
      dat_s2    <= dat_s1;
      filt_prev <= filt_clk;
      if (clk_s2 != filt_clk) begin
        if (filt_cnt == 8'(FILTER_LEN - 1)) begin
          filt_clk <= clk_s2;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 8'd1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign fall = filt_prev & ~filt_clk;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      tmo_cnt <= '0;
      byte_q  <= '0;
      err_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      tmo_cnt <= tmo_cnt_n;
      byte_q  <= byte_n;
      err_q   <= err_n;
      ready_q <= ready_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    tmo_cnt_n = tmo_cnt;
    byte_n    = byte_q;
    err_n     = err_q;
    ready_n   = 1'b0;
    case (state)
      IDLE: begin
        if (fall && bus.READ_ENABLE && !dat_s2) begin
          state_n   = RECEIVE;
          bit_cnt_n = '0;
          tmo_cnt_n = '0;
        end
      end
      RECEIVE: begin
        // Ten shifts leave D0..D7 in [7:0], parity in [8], stop in [9].
        if (fall) begin
          shift_n   = {dat_s2, shift[9:1]};
          bit_cnt_n = bit_cnt + 4'd1;
          tmo_cnt_n = '0;
          if (bit_cnt == 4'd9) state_n = CHECK;
        end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state_n   = IDLE;
          tmo_cnt_n = '0;
        end else begin
          tmo_cnt_n = tmo_cnt + 1'b1;
        end
      end
      CHECK: begin
        byte_n  = shift[7:0];
        err_n   = {~shift[9], ~(^shift[8:0])};
        ready_n = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.BYTE_READ       = byte_q;
  assign bus.BYTE_ERROR_CODE = err_q;
  assign bus.BYTE_READY      = ready_q;
  assign bus.fsm_state       = state;
endmodule
